// File: rtl/fpu_div_pkg.sv
// Shared widths and FSM encoding for the 8/4 restoring divider.
// Imported by the divider top and its iteration step.
package fpu_div_pkg;

    localparam int DVD_W = 8;
    localparam int DVS_W = 4;
    localparam int PR_W  = 5;
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift in a dividend bit,
// then trial-subtract the divisor.
module div_step
    import fpu_div_pkg::*;
(
    input  logic [PR_W-1:0]  pr,
    input  logic             dbit,
    input  logic [DVS_W-1:0] divisor,
    output logic [PR_W-1:0]  pr_next,
    output logic             qbit
);

    logic [PR_W-1:0] shifted;
    logic [PR_W-1:0] dvs_ext;

    always_comb begin
        shifted = {pr[PR_W-2:0], dbit};
        dvs_ext = {1'b0, divisor};
        qbit    = (shifted >= dvs_ext);
        pr_next = qbit ? (shifted - dvs_ext) : shifted;
    end

endmodule

// File: rtl/restoring_divider8.sv
// 8-bit by 4-bit unsigned restoring divider, one quotient bit per cycle,
// with valid/ready handshakes on both operand and result sides.
module restoring_divider8
    import fpu_div_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DVD_W-1:0] quotient,
    output logic [DVS_W-1:0] remainder,
    output logic             dbz
);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [PR_W-1:0]  pr;
    logic [PR_W-1:0]  pr_nx;
    logic [DVD_W-1:0] dvd;
    logic [DVS_W-1:0] dvs;
    logic             qbit;

    // dvd doubles as the quotient shift register: dividend bits leave
    // at the top while quotient bits enter at the bottom.
    div_step u_step (
        .pr      (pr),
        .dbit    (dvd[DVD_W-1]),
        .divisor (dvs),
        .pr_next (pr_nx),
        .qbit    (qbit)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nx = (divisor == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            pr        <= '0;
            dvd       <= '0;
            dvs       <= '0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvd <= dividend;
                        dvs <= divisor;
                        pr  <= '0;
                        if (divisor == '0) begin
                            quotient  <= '1;
                            remainder <= '0;
                            dbz       <= 1'b1;
                        end else begin
                            cnt <= 3'd7;
                        end
                    end
                end
                BUSY: begin
                    pr  <= pr_nx;
                    dvd <= {dvd[DVD_W-2:0], qbit};
                    if (cnt == '0) begin
                        quotient  <= {dvd[DVD_W-2:0], qbit};
                        remainder <= pr_nx[DVS_W-1:0];
                        dbz       <= 1'b0;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_restoring_divider8.sv
// Scoreboard bench for restoring_divider8: directed cases, reset abort,
// backpressure and a full operand sweep with random out_ready.
module tb_restoring_divider8;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       dbz;

    typedef struct packed {
        logic [7:0] q;
        logic [3:0] r;
        logic       z;
    } res_t;

    res_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    restoring_divider8 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input logic [7:0] a, input logic [3:0] b);
        res_t m;
        int   qi;
        int   ri;
        if (b == 4'd0) begin
            m.q = 8'hFF;
            m.r = 4'h0;
            m.z = 1'b1;
        end else begin
            qi  = int'(a) / int'(b);
            ri  = int'(a) % int'(b);
            m.q = qi[7:0];
            m.r = ri[3:0];
            m.z = 1'b0;
        end
        return m;
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge, idle.
    // hold < 0 means random out_ready, otherwise hold stall cycles.
    task automatic do_op(input logic [7:0] a, input logic [3:0] b,
                         input int hold);
        res_t exp;
        int   n;
        int   waited;
        logic rel;
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        sb.push_back(model(a, b));
        @(negedge clk);
        in_valid = 1'b0;
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
        n = 0;
        while (!out_valid && n < 20) begin
            chk("in_ready_busy", in_ready, 0);
            @(negedge clk);
            n++;
        end
        chk("latency", n, (b == 4'd0) ? 0 : 8);
        exp    = sb.pop_front();
        waited = 0;
        do begin
            chk("quotient", quotient, exp.q);
            chk("remainder", remainder, exp.r);
            chk("dbz", dbz, exp.z);
            chk("in_ready_done", in_ready, 0);
            rel = (hold < 0) ? 1'($urandom_range(0, 1)) : (waited >= hold);
            out_ready = rel;
            in_valid  = 1'b1;
            dividend  = 8'($urandom);
            divisor   = 4'($urandom);
            @(negedge clk);
            waited++;
        end while (!rel && waited < 40);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("handshake_idle", {out_valid, in_ready}, 2'b01);
        chk("hold_q_idle", quotient, exp.q);
        chk("hold_r_idle", remainder, exp.r);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        @(negedge clk);
        chk("rst_state", {out_valid, in_ready, dbz}, 3'b010);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        rst = 1'b0;

        do_op(8'd200, 4'd7, 0);
        do_op(8'd255, 4'd15, 1);
        do_op(8'd5, 4'd9, 0);
        do_op(8'd13, 4'd0, 3);

        in_valid = 1'b1;
        dividend = 8'd100;
        divisor  = 4'd3;
        sb.push_back(model(8'd100, 4'd3));
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy", {out_valid, in_ready}, 2'b00);
        chk("mid_busy_q", quotient, 8'hFF);
        rst = 1'b1;
        #1;
        chk("abort_state", {out_valid, in_ready, dbz}, 3'b010);
        chk("abort_q", quotient, 0);
        chk("abort_r", remainder, 0);
        void'(sb.pop_back());
        @(negedge clk);
        rst = 1'b0;
        do_op(8'd100, 4'd3, 2);
        chk("q_100_3", quotient, 33);
        chk("r_100_3", remainder, 1);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("no_result_after_abort", out_valid, 0);
        end

        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                do_op(8'(a), 4'(b), -1);
            end
        end

        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
